oclib_async_req_ack_to_ready_valid: RTL and testbench

//  Receive side of a 4-phase async req/ack link: captures a word from a sender in another clock domain
//  and presents it on a local ready/valid interface. Sits directly downstream of the ready/valid->req/ack

---
 rtl/oclib_async_req_ack_to_ready_valid.sv | 137 +++++++++++++
 tb/tb_oclib_async_req_ack_to_ready_valid.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oclib_async_req_ack_to_ready_valid.sv
// Receive side of a 4-phase req/ack CDC link.
// The word is captured from the sender domain into a 2-entry buffer and presented as ready/valid.
module oclib_async_req_ack_to_ready_valid #(
    parameter int Width         = 8,
    parameter int SyncStages    = 2,
    parameter bit ResetSync     = 1'b0,
    parameter int ResetPipeline = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [Width-1:0] inData,
    input  logic             inReq,
    output logic             inAck,
    output logic [Width-1:0] outData,
    output logic             outValid,
    input  logic             outReady
);

    typedef enum logic {StIdle, StAck} state_t;

    logic w_rst_sync_n;
    logic w_rst_n;

    // Reset assertion is always asynchronous; only the release is retimed here.
    generate
        if (ResetSync) begin : g_rst_sync
            logic [1:0] r_rst_sync;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) r_rst_sync <= '0;
                else        r_rst_sync <= {r_rst_sync[0], 1'b1};
            end
            assign w_rst_sync_n = r_rst_sync[1];
        end else begin : g_rst_direct
            assign w_rst_sync_n = reset;
        end

        if (ResetPipeline > 0) begin : g_rst_pipe
            logic [ResetPipeline:1] r_rst_pipe;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_rst_pipe <= '0;
                end else begin
                    r_rst_pipe[1] <= w_rst_sync_n;
                    for (int i = 2; i <= ResetPipeline; i++) r_rst_pipe[i] <= r_rst_pipe[i-1];
                end
            end
            assign w_rst_n = r_rst_pipe[ResetPipeline];
        end else begin : g_rst_nopipe
            assign w_rst_n = w_rst_sync_n;
        end
    endgenerate

    logic [SyncStages-1:0] r_req_sync;
    logic                  w_req_sync;
    state_t                r_state;
    state_t                w_state_next;
    logic                  r_ack;
    logic                  w_ack_next;
    logic [1:0]            r_count;
    logic [Width-1:0]      r_head;
    logic [Width-1:0]      r_tail;
    logic                  w_push;
    logic                  w_pop;

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_req_sync <= '0;
        end else begin
            r_req_sync[0] <= inReq;
            for (int i = 1; i < SyncStages; i++) r_req_sync[i] <= r_req_sync[i-1];
        end
    end

    assign w_req_sync = r_req_sync[SyncStages-1];
    assign w_pop      = (r_count != 2'd0) && outReady;

    // A pop on the same edge frees a slot, so a full buffer may still accept.
    always_comb begin
        w_state_next = r_state;
        w_ack_next   = r_ack;
        w_push       = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_req_sync && ((r_count != 2'd2) || w_pop)) begin
                    w_push       = 1'b1;
                    w_ack_next   = 1'b1;
                    w_state_next = StAck;
                end
            end
            StAck: begin
                if (!w_req_sync) begin
                    w_ack_next   = 1'b0;
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_ack_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= StIdle;
            r_ack   <= 1'b0;
            r_count <= 2'd0;
            r_head  <= '0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_ack_next;
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= inData;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) r_head <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: r_head <= (r_count == 2'd2) ? r_tail : inData;
                default: ;
            endcase
        end
    end

    // Second slot only ever feeds the head, so it carries no reset.
    always_ff @(posedge clock) begin
        if (w_push && (((r_count == 2'd1) && !w_pop) || ((r_count == 2'd2) && w_pop)))
            r_tail <= inData;
    end

    assign inAck    = r_ack;
    assign outData  = r_head;
    assign outValid = (r_count != 2'd0);

endmodule

// File: tb/tb_oclib_async_req_ack_to_ready_valid.sv
// Bench for oclib_async_req_ack_to_ready_valid: directed handshake scenarios on a SyncStages=2 instance,
// then a randomized 4-phase soak on SyncStages=2 and 3 instances against a FIFO reference queue.
module tb_oclib_async_req_ack_to_ready_valid;

    localparam int NWORDS = 2000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data   [2];
    logic       in_req    [2];
    logic       in_ack    [2];
    logic [7:0] out_data  [2];
    logic       out_valid [2];
    logic       out_ready [2];

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic send_abort [2];

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    initial forever #5 clk = ~clk;

    oclib_async_req_ack_to_ready_valid #(.Width(8), .SyncStages(2)) u_dut_s2 (
        .clock(clk), .reset(rst_n), .inData(in_data[0]), .inReq(in_req[0]), .inAck(in_ack[0]),
        .outData(out_data[0]), .outValid(out_valid[0]), .outReady(out_ready[0])
    );

    oclib_async_req_ack_to_ready_valid #(.Width(8), .SyncStages(3)) u_dut_s3 (
        .clock(clk), .reset(rst_n), .inData(in_data[1]), .inReq(in_req[1]), .inAck(in_ack[1]),
        .outData(out_data[1]), .outValid(out_valid[1]), .outReady(out_ready[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int idx, input logic lvl, input string tag);
        int t = 0;
        while (in_ack[idx] !== lvl && t < 200) begin
            tick(1);
            t++;
        end
        chk(tag, in_ack[idx], lvl);
    endtask

    task automatic send(input int idx, input logic [7:0] d);
        in_data[idx] = d;
        in_req[idx]  = 1'b1;
        wait_ack(idx, 1'b1, "send_ack_rise");
        in_req[idx]  = 1'b0;
        wait_ack(idx, 1'b0, "send_ack_fall");
    endtask

    function automatic int qsize(input int idx);
        return (idx == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Each ack toggle must follow a req toggle and settle at the req level.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic prev_req = 1'b0;
        logic prev_ack = 1'b0;
        logic req_moved = 1'b0;
        always @(in_req[g] or in_ack[g]) begin
            if (in_req[g] !== prev_req) begin
                req_moved = 1'b1;
                prev_req  = in_req[g];
            end
            if (in_ack[g] !== prev_ack) begin
                if (mon_en) chk("ack_follows_req", {30'd0, req_moved, in_ack[g]}, {30'd0, 1'b1, in_req[g]});
                req_moved = 1'b0;
                prev_ack  = in_ack[g];
            end
        end
    end

    task automatic sender(input int idx, input int n);
        int         g;
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            g = $urandom_range(0, 3);
            if (g > 0) tick(g);
            d = 8'($urandom);
            if (idx == 0) exp_q0.push_back(d);
            else          exp_q1.push_back(d);
            in_data[idx] = d;
            in_req[idx]  = 1'b1;
            wait_ack(idx, 1'b1, "soak_ack_rise");
            if (in_ack[idx] !== 1'b1) begin
                send_abort[idx] = 1'b1;
                break;
            end
            g = $urandom_range(0, 2);
            if (g > 0) tick(g);
            in_req[idx]  = 1'b0;
            in_data[idx] = 8'($urandom);
            wait_ack(idx, 1'b0, "soak_ack_fall");
            if (in_ack[idx] !== 1'b0) begin
                send_abort[idx] = 1'b1;
                break;
            end
        end
    endtask

    task automatic consumer(input int idx, input int n);
        int         got = 0;
        int         cyc = 0;
        int         qs;
        logic [7:0] e;
        while (got < n && cyc < 60000 && !send_abort[idx]) begin
            @(negedge clk);
            cyc++;
            out_ready[idx] = ($urandom_range(0, 3) != 0);
            if (out_valid[idx] && out_ready[idx]) begin
                qs = qsize(idx);
                chk("soak_no_extra_word", {31'd0, qs != 0}, 32'd1);
                if (qs != 0) begin
                    e = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk("soak_data_order", {24'd0, out_data[idx]}, {24'd0, e});
                end
                got++;
            end
        end
        @(posedge clk);
        #1;
        out_ready[idx] = 1'b0;
        chk("soak_word_count", got, n);
    endtask

    task automatic soak(input int idx, input int n);
        fork
            sender(idx, n);
            consumer(idx, n);
        join
        tick(2);
        chk("soak_queue_empty", qsize(idx), 0);
        chk("soak_final_valid", {31'd0, out_valid[idx]}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_req[i]     = 1'b0;
            in_data[i]    = 8'h00;
            out_ready[i]  = 1'b0;
            send_abort[i] = 1'b0;
        end
        in_req[0]  = 1'b1;
        in_data[0] = 8'hFF;

        // Reset held with a pending request
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("rst_ack", {31'd0, in_ack[0]}, 32'd0);
            chk("rst_valid", {31'd0, out_valid[0]}, 32'd0);
            chk("rst_data", {24'd0, out_data[0]}, 32'd0);
        end
        in_req[0] = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("idle_ack", {31'd0, in_ack[0]}, 32'd0);
        chk("idle_valid", {31'd0, out_valid[0]}, 32'd0);

        // Single word latency
        in_data[0] = 8'hA5;
        in_req[0]  = 1'b1;
        tick(1);
        chk("t2_e0_ack", {31'd0, in_ack[0]}, 32'd0);
        chk("t2_e0_valid", {31'd0, out_valid[0]}, 32'd0);
        tick(1);
        chk("t2_e1_ack", {31'd0, in_ack[0]}, 32'd0);
        tick(1);
        chk("t2_e2_ack", {31'd0, in_ack[0]}, 32'd1);
        chk("t2_e2_valid", {31'd0, out_valid[0]}, 32'd1);
        chk("t2_e2_data", {24'd0, out_data[0]}, 32'hA5);
        out_ready[0] = 1'b1;
        tick(1);
        chk("t2_popped", {31'd0, out_valid[0]}, 32'd0);
        out_ready[0] = 1'b0;
        in_req[0]    = 1'b0;
        tick(2);
        chk("t2_ack_hold", {31'd0, in_ack[0]}, 32'd1);
        tick(1);
        chk("t2_ack_fall", {31'd0, in_ack[0]}, 32'd0);

        // Backpressure with a full buffer
        send(0, 8'h11);
        send(0, 8'h22);
        in_data[0] = 8'h33;
        in_req[0]  = 1'b1;
        tick(8);
        chk("t3_full_noack", {31'd0, in_ack[0]}, 32'd0);
        chk("t3_head_stable", {24'd0, out_data[0]}, 32'h11);
        chk("t3_valid", {31'd0, out_valid[0]}, 32'd1);
        out_ready[0] = 1'b1;
        tick(1);
        out_ready[0] = 1'b0;
        chk("t3_pop_capture_ack", {31'd0, in_ack[0]}, 32'd1);
        chk("t3_head_22", {24'd0, out_data[0]}, 32'h22);
        in_req[0] = 1'b0;
        wait_ack(0, 1'b0, "t3_ack_fall");
        chk("t3_head_22_held", {24'd0, out_data[0]}, 32'h22);
        out_ready[0] = 1'b1;
        tick(1);
        chk("t3_head_33", {24'd0, out_data[0]}, 32'h33);
        chk("t3_valid_33", {31'd0, out_valid[0]}, 32'd1);
        tick(1);
        chk("t3_drained", {31'd0, out_valid[0]}, 32'd0);
        out_ready[0] = 1'b0;

        // Simultaneous push and pop at count 1
        send(0, 8'h40);
        in_data[0] = 8'h41;
        in_req[0]  = 1'b1;
        tick(2);
        chk("t4_pre_ack", {31'd0, in_ack[0]}, 32'd0);
        chk("t4_head_40", {24'd0, out_data[0]}, 32'h40);
        out_ready[0] = 1'b1;
        tick(1);
        out_ready[0] = 1'b0;
        chk("t4_ack", {31'd0, in_ack[0]}, 32'd1);
        chk("t4_head_41", {24'd0, out_data[0]}, 32'h41);
        chk("t4_valid", {31'd0, out_valid[0]}, 32'd1);
        tick(1);
        chk("t4_head_41_held", {24'd0, out_data[0]}, 32'h41);
        in_req[0] = 1'b0;
        wait_ack(0, 1'b0, "t4_ack_fall");
        out_ready[0] = 1'b1;
        tick(1);
        chk("t4_drained", {31'd0, out_valid[0]}, 32'd0);
        out_ready[0] = 1'b0;

        // Asynchronous reset while acknowledging
        in_data[0] = 8'h55;
        in_req[0]  = 1'b1;
        wait_ack(0, 1'b1, "t5_ack");
        chk("t5_valid", {31'd0, out_valid[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_ack", {31'd0, in_ack[0]}, 32'd0);
        chk("t5_async_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("t5_async_data", {24'd0, out_data[0]}, 32'd0);
        #2 rst_n = 1'b1;
        wait_ack(0, 1'b1, "t5_reack");
        chk("t5_recapture", {24'd0, out_data[0]}, 32'h55);
        tick(3);
        chk("t5_ack_held", {31'd0, in_ack[0]}, 32'd1);
        in_req[0] = 1'b0;
        wait_ack(0, 1'b0, "t5_ack_fall");
        out_ready[0] = 1'b1;
        tick(1);
        chk("t5_single_copy", {31'd0, out_valid[0]}, 32'd0);
        out_ready[0] = 1'b0;

        // Random soak on both synchronizer depths
        tick(2);
        mon_en = 1'b1;
        fork
            soak(0, NWORDS);
            soak(1, NWORDS);
        join
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
